// File: rtl/apb_master_arbiter_if.sv
// rtl/apb_master_arbiter_if.sv - requester, response and APB bus signals of apb_master_arbiter
interface apb_master_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req0_valid;
  logic              req0_write;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;
  logic              req1_valid;
  logic              req1_write;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;
  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_rdata;
  logic              rsp0_err;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_rdata;
  logic              rsp1_err;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic [DATA_W-1:0] prdata;

  modport master (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_rdata, rsp0_err,
    output rsp1_valid, rsp1_rdata, rsp1_err,
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, prdata
  );

  modport slave (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_rdata, rsp0_err,
    input  rsp1_valid, rsp1_rdata, rsp1_err,
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, prdata
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - round-robin two-port APB master, one transfer at a time
// Optional ACCESS-phase timeout abort: define APB_TIMEOUT_EN.
module apb_master_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                 pclk,
  input  logic                 preset,
  apb_master_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("apb_master_arbiter: TIMEOUT must be >= 2");
  end

  state_t            state;
  logic              rr;
  logic              owner;
  logic              grant;
  logic              accept;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [1:0]        rsp_valid_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic [DATA_W-1:0] cap_rdata;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT);
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        err_q;
`endif

  // rr names the port that wins a collision; a lone requester always wins.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid)
      grant = rr;
    else if (bus.req1_valid)
      grant = 1'b1;
  end

  assign accept    = (state == IDLE) && !preset &&
                     (grant ? bus.req1_valid : bus.req0_valid);
  assign sel_write = grant ? bus.req1_write : bus.req0_write;
  assign sel_addr  = grant ? bus.req1_addr  : bus.req0_addr;
  assign sel_wdata = grant ? bus.req1_wdata : bus.req0_wdata;
  assign cap_rdata = pwrite_q ? '0 : bus.prdata;

  assign bus.req0_ready = accept && !grant;
  assign bus.req1_ready = accept && grant;
  assign bus.rsp0_valid = rsp_valid_q[0];
  assign bus.rsp1_valid = rsp_valid_q[1];
  assign bus.rsp0_rdata = rdata0_q;
  assign bus.rsp1_rdata = rdata1_q;
  assign bus.psel       = psel_q;
  assign bus.penable    = penable_q;
  assign bus.pwrite     = pwrite_q;
  assign bus.paddr      = paddr_q;
  assign bus.pwdata     = pwdata_q;

`ifdef APB_TIMEOUT_EN
  assign bus.rsp0_err = err_q[0];
  assign bus.rsp1_err = err_q[1];
`else
  assign bus.rsp0_err = 1'b0;
  assign bus.rsp1_err = 1'b0;
`endif

  always_ff @(posedge pclk) begin
    if (preset) begin
      state       <= IDLE;
      rr          <= 1'b0;
      owner       <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 2'b00;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
`ifdef APB_TIMEOUT_EN
      cnt         <= '0;
      err_q       <= 2'b00;
`endif
    end else begin
      rsp_valid_q <= 2'b00;
      case (state)
        IDLE: begin
          if (accept) begin
            owner    <= grant;
            rr       <= ~grant;
            pwrite_q <= sel_write;
            paddr_q  <= sel_addr;
            pwdata_q <= sel_wdata;
            psel_q   <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state     <= ACCESS;
`ifdef APB_TIMEOUT_EN
          cnt       <= '0;
`endif
        end
        ACCESS: begin
          // pready on the final allowed cycle still completes normally.
          if (bus.pready) begin
            psel_q             <= 1'b0;
            penable_q          <= 1'b0;
            state              <= IDLE;
            rsp_valid_q[owner] <= 1'b1;
            if (owner) rdata1_q <= cap_rdata;
            else       rdata0_q <= cap_rdata;
`ifdef APB_TIMEOUT_EN
            err_q[owner]       <= 1'b0;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            psel_q             <= 1'b0;
            penable_q          <= 1'b0;
            state              <= IDLE;
            rsp_valid_q[owner] <= 1'b1;
            err_q[owner]       <= 1'b1;
            if (owner) rdata1_q <= '0;
            else       rdata0_q <= '0;
          end else begin
            cnt <= cnt + 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - directed vector bench for apb_master_arbiter (APB_TIMEOUT_EN aware)
module tb_apb_master_arbiter;
  logic pclk;
  logic preset;
  int   total = 0;
  int   bad   = 0;

  apb_master_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  apb_master_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(16)) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  // Slave memory: answers after slave_waits extra ACCESS cycles, garbage prdata otherwise.
  logic [7:0] mem [256];
  int         slave_waits = 0;
  int         slave_cnt   = 0;

  always @(negedge pclk) begin
    if (bus.psel && bus.penable) begin
      if (slave_cnt >= slave_waits) begin
        bus.pready = 1'b1;
        bus.prdata = mem[bus.paddr];
        if (bus.pwrite) mem[bus.paddr] = bus.pwdata;
        slave_cnt = 0;
      end else begin
        bus.pready = 1'b0;
        bus.prdata = 8'hEE;
        slave_cnt++;
      end
    end else begin
      bus.pready = 1'b0;
      bus.prdata = 8'hEE;
      slave_cnt  = 0;
    end
  end

  typedef struct {
    int         port;
    logic       write;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         waits;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int port, input logic v, input logic w,
                       input logic [7:0] a, input logic [7:0] d);
    if (port == 0) begin
      bus.req0_valid = v; bus.req0_write = w; bus.req0_addr = a; bus.req0_wdata = d;
    end else begin
      bus.req1_valid = v; bus.req1_write = w; bus.req1_addr = a; bus.req1_wdata = d;
    end
  endtask

  task automatic wait_rsp(input string name, input int port, input logic [7:0] exp_rd,
                          input logic exp_err);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge pclk); #1;
      if (port == 1 ? bus.rsp1_valid : bus.rsp0_valid) found = 1;
    end
    check({name, " rsp_seen"}, 32'(found), 32'd1);
    if (found) begin
      check({name, " rdata"}, port == 1 ? bus.rsp1_rdata : bus.rsp0_rdata, exp_rd);
      check({name, " err"}, port == 1 ? bus.rsp1_err : bus.rsp0_err, exp_err);
    end
  endtask

  task automatic run_xfer(input string name, input int port, input logic w,
                          input logic [7:0] a, input logic [7:0] d,
                          input int waits, input logic [7:0] exp_rd);
    int acc = 0;
    slave_waits = waits;
    @(negedge pclk);
    drive(port, 1'b1, w, a, d);
    #1;
    check({name, " ready"}, port == 1 ? bus.req1_ready : bus.req0_ready, 32'd1);
    check({name, " rsp_idle"}, {bus.rsp0_valid, bus.rsp1_valid}, 32'd0);
    @(negedge pclk);
    drive(port, 1'b0, w, a, d);
    #1;
    check({name, " setup"}, {bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata},
          {13'd0, 1'b1, 1'b0, w, a, d});
    repeat (waits + 1) begin
      @(negedge pclk); #1;
      if (bus.psel && bus.penable && bus.paddr == a && bus.pwdata == d) acc++;
    end
    check({name, " access_cycles"}, acc, waits + 1);
    @(negedge pclk); #1;
    check({name, " rsp_pulse"}, {bus.psel, bus.rsp0_valid, bus.rsp1_valid},
          {29'd0, 1'b0, port == 0, port == 1});
    check({name, " rdata"}, port == 1 ? bus.rsp1_rdata : bus.rsp0_rdata, exp_rd);
    check({name, " err"}, port == 1 ? bus.rsp1_err : bus.rsp0_err, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b2b_addr [4];
    logic [7:0] b2b_exp  [4];
    bit         seen;
    int         acc;

    vecs[0] = '{0, 1'b1, 8'h05, 8'hA5, 0,  8'h00};
    vecs[1] = '{0, 1'b0, 8'h05, 8'h00, 1,  8'hA5};
    vecs[2] = '{1, 1'b1, 8'h80, 8'h3C, 0,  8'h00};
    vecs[3] = '{1, 1'b0, 8'h80, 8'h00, 2,  8'h3C};
    vecs[4] = '{0, 1'b0, 8'hFF, 8'h00, 0,  8'h00};
    vecs[5] = '{1, 1'b1, 8'hFF, 8'h5A, 3,  8'h00};
    vecs[6] = '{1, 1'b1, 8'h05, 8'h77, 0,  8'h00};
    vecs[7] = '{0, 1'b0, 8'h05, 8'h00, 15, 8'h77};
    b2b_addr = '{8'h05, 8'h80, 8'hFF, 8'h10};
    b2b_exp  = '{8'h77, 8'h3C, 8'h5A, 8'h11};

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    preset = 1'b1;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(negedge pclk);
    drive(0, 1'b1, 1'b0, 8'h00, 8'h00);
    #1;
    check("reset ready_blocked", bus.req0_ready, 32'd0);
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge pclk);
    preset = 1'b0;
    #1;
    check("reset apb", {bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata}, 32'd0);
    check("reset rsp", {bus.rsp0_valid, bus.rsp0_err, bus.rsp0_rdata,
                        bus.rsp1_valid, bus.rsp1_err, bus.rsp1_rdata}, 32'd0);

    // Collisions from reset: port0, then port1, then port0 again.
    slave_waits = 0;
    @(negedge pclk);
    drive(0, 1'b1, 1'b1, 8'h10, 8'h11);
    drive(1, 1'b1, 1'b1, 8'h20, 8'h22);
    #1;
    check("coll1 ready", {bus.req0_ready, bus.req1_ready}, 32'b10);
    @(negedge pclk);
    drive(0, 1'b0, 1'b1, 8'h10, 8'h11);
    #1;
    check("coll1 setup_addr", {bus.psel, bus.penable, bus.paddr}, {22'd0, 1'b1, 1'b0, 8'h10});
    wait_rsp("coll1 p0", 0, 8'h00, 1'b0);
    check("coll1 p1_ready", bus.req1_ready, 32'd1);
    @(negedge pclk);
    drive(1, 1'b0, 1'b1, 8'h20, 8'h22);
    #1;
    check("coll1 p1_setup_addr", {bus.psel, bus.penable, bus.paddr}, {22'd0, 1'b1, 1'b0, 8'h20});
    wait_rsp("coll1 p1", 1, 8'h00, 1'b0);
    @(negedge pclk);
    drive(0, 1'b1, 1'b0, 8'h10, 8'h00);
    drive(1, 1'b1, 1'b0, 8'h20, 8'h00);
    #1;
    check("coll3 ready", {bus.req0_ready, bus.req1_ready}, 32'b10);
    @(negedge pclk);
    drive(0, 1'b0, 1'b0, 8'h10, 8'h00);
    wait_rsp("coll3 p0", 0, 8'h11, 1'b0);
    check("coll3 p1_ready", bus.req1_ready, 32'd1);
    @(negedge pclk);
    drive(1, 1'b0, 1'b0, 8'h20, 8'h00);
    wait_rsp("coll3 p1", 1, 8'h22, 1'b0);

    for (int i = 0; i < 8; i++)
      run_xfer($sformatf("vec%0d", i), vecs[i].port, vecs[i].write, vecs[i].addr,
               vecs[i].wdata, vecs[i].waits, vecs[i].exp_rdata);

    // Port 1 streams four reads with valid held: one psel-low cycle between transfers.
    slave_waits = 0;
    @(negedge pclk);
    drive(1, 1'b1, 1'b0, b2b_addr[0], 8'h00);
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("b2b%0d ready_gap", k), {bus.req1_ready, bus.psel}, 32'b10);
      @(negedge pclk); #1;
      check($sformatf("b2b%0d setup", k), {bus.psel, bus.penable, bus.paddr},
            {22'd0, 1'b1, 1'b0, b2b_addr[k]});
      @(negedge pclk); #1;
      check($sformatf("b2b%0d access", k), {bus.psel, bus.penable}, 32'b11);
      @(negedge pclk);
      if (k == 3) drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
      else        drive(1, 1'b1, 1'b0, b2b_addr[k+1], 8'h00);
      #1;
      check($sformatf("b2b%0d rsp", k), {bus.rsp1_valid, bus.rsp1_rdata}, {23'd0, 1'b1, b2b_exp[k]});
    end

    // Reset in ACCESS: bus drops, no response, command discarded.
    slave_waits = 1000;
    @(negedge pclk);
    drive(0, 1'b1, 1'b1, 8'h40, 8'h99);
    #1;
    check("abort ready", bus.req0_ready, 32'd1);
    @(negedge pclk);
    drive(0, 1'b0, 1'b1, 8'h40, 8'h99);
    @(negedge pclk);
    @(negedge pclk); #1;
    check("abort in_access", {bus.psel, bus.penable}, 32'b11);
    preset = 1'b1;
    @(negedge pclk); #1;
    check("abort bus_reset", {bus.psel, bus.penable, bus.paddr, bus.pwdata}, 32'd0);
    preset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge pclk); #1;
      if (bus.rsp0_valid || bus.rsp1_valid) seen = 1;
    end
    check("abort no_rsp", 32'(seen), 32'd0);
    run_xfer("after_abort", 0, 1'b0, 8'h40, 8'h00, 0, 8'h00);

    // Slave never answers.
    slave_waits = 1000;
    @(negedge pclk);
    drive(1, 1'b1, 1'b0, 8'h80, 8'h00);
    @(negedge pclk);
    drive(1, 1'b0, 1'b0, 8'h80, 8'h00);
`ifdef APB_TIMEOUT_EN
    acc  = 0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge pclk); #1;
      if (bus.rsp1_valid) seen = 1;
      else if (bus.psel && bus.penable) acc++;
    end
    check("timeout rsp_seen", 32'(seen), 32'd1);
    check("timeout access_cycles", acc, 32'd16);
    check("timeout rsp", {bus.psel, bus.rsp1_err, bus.rsp1_rdata}, {23'd0, 1'b0, 1'b1, 8'h00});
`else
    seen = 0;
    repeat (40) begin
      @(negedge pclk); #1;
      if (bus.rsp0_valid || bus.rsp1_valid) seen = 1;
    end
    check("hang no_rsp", 32'(seen), 32'd0);
    check("hang in_access", {bus.psel, bus.penable, bus.paddr}, {22'd0, 1'b1, 1'b1, 8'h80});
    @(negedge pclk);
    preset = 1'b1;
    @(negedge pclk);
    preset = 1'b0;
`endif
    run_xfer("recover", 1, 1'b0, 8'h80, 8'h00, 0, 8'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
